// File: rtl/dffn_pipe_sr.sv
// dffn_pipe_sr: DEPTH-stage, WIDTH-bit elastic register pipeline with a
// valid/ready handshake at both ends and an occupancy count.
// Clocked on the falling CLK edge by default (NEG_EDGE=1), rising edge otherwise.
// RSTB (active-low, async) loads RST_VAL into every stage; SETB (active-low,
// async) loads SET_VAL; RSTB dominates. Both clear all valid bits.
// Optional scan chain: define DFFN_PIPE_SR_SCAN_EN to add SE/SI/SO.
module dffn_pipe_sr #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 2,
    parameter int               NEG_EDGE = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter logic [WIDTH-1:0] SET_VAL  = '1
) (
    input  logic                       CLK,
    input  logic                       RSTB,
    input  logic                       SETB,
`ifdef DFFN_PIPE_SR_SCAN_EN
    input  logic                       SE,
    input  logic                       SI,
    output logic                       SO,
`endif
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic                        clk_act;
    logic                        async_n;
    logic [WIDTH-1:0]            clr_bit;
    logic [WIDTH-1:0]            pre_bit;
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            v_next;
    logic [DEPTH-1:0]            mv;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] d_next;

    // The active edge is a fixed build-time choice; inverting CLK lets every
    // flop below be written as a plain posedge flop.
    assign clk_act = (NEG_EDGE != 0) ? ~CLK : CLK;

    // Valid bits are cleared by either async input.
    assign async_n = RSTB & SETB;

    // Per-bit async clear/preset: each data bit becomes a flop with both an
    // async clear and an async preset, so releasing RSTB while SETB is still
    // low hands over directly to the SET value without waiting for a clock.
    always_comb begin
        clr_bit = '0;
        pre_bit = '0;
        if (!RSTB) begin
            clr_bit = ~RST_VAL;
            pre_bit = RST_VAL;
        end else if (!SETB) begin
            clr_bit = ~SET_VAL;
            pre_bit = SET_VAL;
        end
    end

    // Move chain from the output side back, then the per-stage load/hold
    // decisions; the scan mode overrides all of it when enabled.
    always_comb begin
        mv       = '0;
        v_next   = v;
        d_next   = d;
        mv[DEPTH-1] = v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            mv[i] = v[i] & (~v[i+1] | mv[i+1]);
        end
        in_ready = ~v[0] | mv[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                if (in_valid && in_ready) begin
                    d_next[0] = in_data;
                    v_next[0] = 1'b1;
                end else if (mv[0]) begin
                    v_next[0] = 1'b0;
                end
            end else begin
                if (mv[i-1]) begin
                    d_next[i] = d[i-1];
                    v_next[i] = 1'b1;
                end else if (mv[i]) begin
                    v_next[i] = 1'b0;
                end
            end
        end
`ifdef DFFN_PIPE_SR_SCAN_EN
        if (SE) begin
            in_ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                d_next[i][0] = (i == 0) ? SI : v[(i == 0) ? 0 : i - 1];
                for (int b = 1; b < WIDTH; b++) begin
                    d_next[i][b] = d[i][b-1];
                end
                v_next[i] = d[i][WIDTH-1];
            end
        end
`endif
    end

    // Valid flags: cleared asynchronously by reset or set, else follow v_next.
    always_ff @(posedge clk_act or negedge async_n) begin
        if (!async_n) begin
            v <= '0;
        end else begin
            v <= v_next;
        end
    end

    // Data flops, one column per bit position so each column shares the same
    // async clear/preset pair.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [DEPTH-1:0] col;

        // Column b of every stage: async clear/preset, else load from d_next.
        always_ff @(posedge clk_act or posedge clr_bit[b] or posedge pre_bit[b]) begin
            if (clr_bit[b]) begin
                col <= '0;
            end else if (pre_bit[b]) begin
                col <= '1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    col[i] <= d_next[i][b];
                end
            end
        end

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            assign d[i][b] = col[i];
        end
    end

    // Occupancy is the number of valid stages.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(v[i]);
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef DFFN_PIPE_SR_SCAN_EN
    assign SO = v[DEPTH-1];
`endif

endmodule

// File: tb/tb_dffn_pipe_sr.sv
// tb_dffn_pipe_sr: randomized and directed checks of dffn_pipe_sr against a
// slot-occupancy model. Three instances: default (DEPTH=2, falling edge),
// DEPTH=4 for bubble collapse, and NEG_EDGE=0/DEPTH=1 for rising-edge use.
// Scan checks are included when DFFN_PIPE_SR_SCAN_EN is defined.
module tb_dffn_pipe_sr;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       setb = 1'b1;

    logic       iv0 = 1'b0, ordy0 = 1'b0, ir0, ov0;
    logic [7:0] id0 = '0, od0;
    logic [1:0] cnt0;

    logic       iv4 = 1'b0, ordy4 = 1'b0, ir4, ov4;
    logic [7:0] id4 = '0, od4;
    logic [2:0] cnt4;

    logic       iv1 = 1'b0, ordy1 = 1'b0, ir1, ov1;
    logic [7:0] id1 = '0, od1;
    logic [0:0] cnt1;

`ifdef DFFN_PIPE_SR_SCAN_EN
    logic se0 = 1'b0, si0 = 1'b0, so0;
    logic se4 = 1'b0, si4 = 1'b0, so4;
    logic se1 = 1'b0, si1 = 1'b0, so1;
`endif

    int nChecks = 0;
    int nFails  = 0;

    bit         mOcc [2][4];
    logic [7:0] mDat [2][4];
    int         mDepth [2];

    always #5 clk = ~clk;

    dffn_pipe_sr #(.WIDTH(8), .DEPTH(2)) dutMain (
        .CLK(clk), .RSTB(rstb), .SETB(setb),
`ifdef DFFN_PIPE_SR_SCAN_EN
        .SE(se0), .SI(si0), .SO(so0),
`endif
        .in_valid(iv0), .in_data(id0), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ready(ordy0), .count(cnt0)
    );

    dffn_pipe_sr #(.WIDTH(8), .DEPTH(4)) dutDeep (
        .CLK(clk), .RSTB(rstb), .SETB(setb),
`ifdef DFFN_PIPE_SR_SCAN_EN
        .SE(se4), .SI(si4), .SO(so4),
`endif
        .in_valid(iv4), .in_data(id4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_ready(ordy4), .count(cnt4)
    );

    dffn_pipe_sr #(.WIDTH(8), .DEPTH(1), .NEG_EDGE(0)) dutRise (
        .CLK(clk), .RSTB(rstb), .SETB(setb),
`ifdef DFFN_PIPE_SR_SCAN_EN
        .SE(se1), .SI(si1), .SO(so1),
`endif
        .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(ordy1), .count(cnt1)
    );

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: slots hold words; the output word leaves if out_ready, then every
    // word steps forward into a free slot (output side first), then a new word
    // enters slot 0 if it is free. rdy reports whether slot 0 is free.
    task automatic modelEdge(input int m, input bit iv, input logic [7:0] id,
                             input bit ordy, input bit commit, output bit rdy);
        bit         occ [4];
        logic [7:0] dat [4];
        int         dep;
        dep = mDepth[m];
        for (int i = 0; i < 4; i++) begin
            occ[i] = mOcc[m][i];
            dat[i] = mDat[m][i];
        end
        if (occ[dep-1] && ordy) occ[dep-1] = 1'b0;
        for (int i = dep - 2; i >= 0; i--) begin
            if (occ[i] && !occ[i+1]) begin
                occ[i+1] = 1'b1;
                dat[i+1] = dat[i];
                occ[i]   = 1'b0;
            end
        end
        rdy = !occ[0];
        if (iv && rdy) begin
            occ[0] = 1'b1;
            dat[0] = id;
        end
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                mOcc[m][i] = occ[i];
                mDat[m][i] = dat[i];
            end
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) mOcc[m][i] = 1'b0;
    endtask

    task automatic applyStimulus(input int m, input bit iv, input logic [7:0] id, input bit ordy);
        if (m == 0) begin iv0 = iv; id0 = id; ordy0 = ordy; end
        else        begin iv4 = iv; id4 = id; ordy4 = ordy; end
    endtask

    // Compare one model instance against its DUT; ready only when inputs are live.
    task automatic checkModel(input int m, input bit withReady, input bit rdy);
        int   dep, pop;
        logic ov, ir;
        logic [7:0] od;
        logic [31:0] cnt;
        dep = mDepth[m];
        pop = 0;
        for (int i = 0; i < dep; i++) pop += int'(mOcc[m][i]);
        if (m == 0) begin ov = ov0; od = od0; ir = ir0; cnt = 32'(cnt0); end
        else        begin ov = ov4; od = od4; ir = ir4; cnt = 32'(cnt4); end
        checkOutput($sformatf("m%0d out_valid", m), 32'(ov), 32'(mOcc[m][dep-1]));
        checkOutput($sformatf("m%0d count", m), cnt, 32'(pop));
        if (mOcc[m][dep-1]) checkOutput($sformatf("m%0d out_data", m), 32'(od), 32'(mDat[m][dep-1]));
        if (withReady) checkOutput($sformatf("m%0d in_ready", m), 32'(ir), 32'(rdy));
    endtask

    // One falling-edge cycle: drive, check, advance model, check after the
    // falling edge and again after the (ignored) rising edge.
    task automatic stepDut(input int m, input bit iv, input logic [7:0] id,
                           input bit ordy, output bit acc);
        bit rdy;
        applyStimulus(m, iv, id, ordy);
        #1;
        modelEdge(m, iv, id, ordy, 1'b0, rdy);
        checkModel(m, 1'b1, rdy);
        acc = iv && rdy;
        modelEdge(m, iv, id, ordy, 1'b1, rdy);
        @(negedge clk); #1;
        checkModel(m, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkModel(m, 1'b0, 1'b0);
    endtask

    initial begin
        bit         acc;
        bit         pendV;
        logic [7:0] pendD;
        bit         iv;
        logic [7:0] id;
        mDepth[0] = 2;
        mDepth[1] = 4;
        modelReset();

        // Reset at start.
        #1 rstb = 1'b0;
        #1;
        checkOutput("reset out_valid", 32'(ov0), 32'h0);
        checkOutput("reset count", 32'(cnt0), 32'h0);
        checkOutput("reset out_data", 32'(od0), 32'h00);
        checkOutput("reset deep out_data", 32'(od4), 32'h00);
        @(posedge clk); #1 rstb = 1'b1;

        // Streaming 01..05 with out_ready high.
        for (int k = 1; k <= 8; k++) begin
            stepDut(0, k <= 5, 8'(k), 1'b1, acc);
            if (k >= 2 && k <= 6) begin
                checkOutput("stream out_valid", 32'(ov0), 32'h1);
                checkOutput("stream out_data", 32'(od0), 32'(k - 1));
            end
        end

        // Back-pressure: A3 waits upstream while full.
        stepDut(0, 1'b1, 8'hA1, 1'b0, acc);
        stepDut(0, 1'b1, 8'hA2, 1'b0, acc);
        stepDut(0, 1'b1, 8'hA3, 1'b0, acc);
        checkOutput("bp count full", 32'(cnt0), 32'h2);
        checkOutput("bp in_ready full", 32'(ir0), 32'h0);
        checkOutput("bp out_data", 32'(od0), 32'hA1);
        stepDut(0, 1'b1, 8'hA3, 1'b1, acc);
        checkOutput("bp count accept+emit", 32'(cnt0), 32'h2);
        checkOutput("bp out_data A2", 32'(od0), 32'hA2);
        stepDut(0, 1'b0, 8'h00, 1'b1, acc);
        checkOutput("bp out_data A3", 32'(od0), 32'hA3);
        stepDut(0, 1'b0, 8'h00, 1'b1, acc);
        checkOutput("bp drained", 32'(ov0), 32'h0);

        // Reset mid-stream with two words in flight.
        stepDut(0, 1'b1, 8'hB1, 1'b0, acc);
        stepDut(0, 1'b1, 8'hB2, 1'b0, acc);
        rstb = 1'b0;
        #1;
        checkOutput("midreset out_valid", 32'(ov0), 32'h0);
        checkOutput("midreset count", 32'(cnt0), 32'h0);
        checkOutput("midreset out_data", 32'(od0), 32'h00);
        modelReset();
        #1 rstb = 1'b1;
        stepDut(0, 1'b1, 8'h11, 1'b1, acc);
        stepDut(0, 1'b1, 8'h11, 1'b1, acc);
        checkOutput("post-reset out_data", 32'(od0), 32'h11);
        checkOutput("post-reset out_valid", 32'(ov0), 32'h1);

        // Set and reset dominance.
        iv0 = 1'b0;
        @(posedge clk); #1 setb = 1'b0;
        #1;
        checkOutput("set out_data", 32'(od0), 32'hFF);
        checkOutput("set count", 32'(cnt0), 32'h0);
        checkOutput("set out_valid", 32'(ov0), 32'h0);
        rstb = 1'b0;
        #1 checkOutput("both low out_data", 32'(od0), 32'h00);
        rstb = 1'b1;
        #1 checkOutput("rstb release out_data", 32'(od0), 32'hFF);
        modelReset();
        @(posedge clk); #1 setb = 1'b1;
        #1 checkOutput("set release count", 32'(cnt0), 32'h0);

        // Randomized traffic; pending words are held stable until accepted.
        pendV = 1'b0;
        pendD = '0;
        for (int k = 0; k < 400; k++) begin
            if (pendV) begin
                iv = 1'b1;
                id = pendD;
            end else begin
                iv = ($urandom_range(0, 3) != 0);
                id = 8'($urandom);
            end
            stepDut(0, iv, id, ($urandom_range(0, 9) < 7), acc);
            pendV = iv && !acc;
            pendD = id;
        end
        stepDut(0, 1'b0, 8'h00, 1'b1, acc);
        stepDut(0, 1'b0, 8'h00, 1'b1, acc);

        // Bubble collapse on DEPTH=4: words at stages 1 and 3.
        stepDut(1, 1'b1, 8'hC1, 1'b0, acc);
        stepDut(1, 1'b0, 8'h00, 1'b0, acc);
        stepDut(1, 1'b1, 8'hC2, 1'b0, acc);
        stepDut(1, 1'b0, 8'h00, 1'b0, acc);
        checkOutput("bubble count", 32'(cnt4), 32'h2);
        checkOutput("bubble out_data", 32'(od4), 32'hC1);
        stepDut(1, 1'b0, 8'h00, 1'b0, acc);
        checkOutput("bubble in_ready", 32'(ir4), 32'h1);
        checkOutput("bubble count after", 32'(cnt4), 32'h2);
        stepDut(1, 1'b0, 8'h00, 1'b1, acc);
        checkOutput("bubble C2 at output", 32'(od4), 32'hC2);
        checkOutput("bubble out_valid", 32'(ov4), 32'h1);
        stepDut(1, 1'b0, 8'h00, 1'b1, acc);

        // Rising-edge, single-stage instance.
        @(negedge clk); #1;
        iv1 = 1'b1; id1 = 8'h5A; ordy1 = 1'b0;
        #1;
        checkOutput("rise in_ready empty", 32'(ir1), 32'h1);
        checkOutput("rise out_valid before", 32'(ov1), 32'h0);
        @(posedge clk); #1;
        checkOutput("rise out_valid", 32'(ov1), 32'h1);
        checkOutput("rise out_data", 32'(od1), 32'h5A);
        checkOutput("rise count", 32'(cnt1), 32'h1);
        checkOutput("rise in_ready full", 32'(ir1), 32'h0);
        iv1 = 1'b0;
        @(negedge clk); #1;
        checkOutput("rise hold on falling", 32'(ov1), 32'h1);
        ordy1 = 1'b1;
        #1 checkOutput("rise in_ready passthrough", 32'(ir1), 32'h1);
        @(posedge clk); #1;
        checkOutput("rise emptied", 32'(ov1), 32'h0);
        checkOutput("rise count empty", 32'(cnt1), 32'h0);

`ifdef DFFN_PIPE_SR_SCAN_EN
        // Scan: pattern 1,0,1 appears on SO after 9 rising edges.
        begin
            logic [2:0] pat;
            pat = 3'b101;
            @(negedge clk); #1;
            se1 = 1'b1;
            #1 checkOutput("scan in_ready", 32'(ir1), 32'h0);
            for (int k = 0; k < 12; k++) begin
                si1 = (k < 3) ? pat[k] : 1'b0;
                @(posedge clk); #1;
                if (k >= 8 && k <= 10) checkOutput("scan SO", 32'(so1), 32'(pat[k-8]));
                @(negedge clk); #1;
            end
            se1 = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dffn_pipe_sr.md
Name: dffn_pipe_sr

Overview:
- Parametrised successor to the single-bit negative-edge set/reset flop.
- A DEPTH-stage, WIDTH-bit elastic register pipeline clocked on a selectable CLK edge (falling by default).
- Asynchronous active-low reset and set, with reset dominant.
- Valid/ready handshake at both ends and an occupancy count; used for retiming and buffering on negative-edge clock domains.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 2, number of register stages (>=1)
- NEG_EDGE, 1, 1 = all flops update on falling CLK; 0 = on rising CLK
- RST_VAL, 0, data value loaded into every stage while RSTB is low
- SET_VAL, all ones, data value loaded into every stage while SETB is low (RSTB high)

Ports:
- CLK  input  1  clock; active edge selected by NEG_EDGE
- RSTB  input  1  reset, asynchronous, active-low
- SETB  input  1  asynchronous preset, active-low; RSTB dominates
- in_valid  input  1  upstream data valid
- in_data  input  WIDTH  upstream data
- in_ready  output  1  pipeline accepts in_data on this active edge
- out_valid  output  1  last stage holds valid data
- out_data  output  WIDTH  last stage data
- out_ready  input  1  downstream accepts out_data
- count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output side): data d[i] (WIDTH bits) and valid bit v[i].
- Async priority, evaluated continuously:
  - RSTB=0: all d[i]=RST_VAL, all v[i]=0, count=0, out_valid=0, out_data=RST_VAL.
  - Else SETB=0: all d[i]=SET_VAL, all v[i]=0, count=0, out_data=SET_VAL.
  - Both low: reset wins. Releasing RSTB while SETB is still low immediately yields the SET state.
- Assertion of either async input takes effect with no clock edge. Clock edges are ignored while either is low.
- Deassertion is not synchronised inside the block; the integrator guarantees recovery/removal to the active edge.
- Move condition (combinational):
  - mv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - mv[i] = v[i] & (!v[i+1] | mv[i+1]).
- in_ready = !v[0] | mv[0]. in_ready is combinational from out_ready through the chain; no ready register.
- On the active edge, for each stage i:
  - Stage 0 loads in_data with v[0]=1 when in_valid & in_ready.
  - Stage i>0 loads d[i-1] with v[i]=1 when mv[i-1].
  - Otherwise, if mv[i], v[i] is cleared; d[i] is held.
  - Otherwise d[i] and v[i] hold.
  - Data of invalid stages is don't-care but is never modified except by a load.
- Latency: empty pipe, in_valid=1, out_ready=1 → out_valid asserts after DEPTH active edges.
- Throughput: one word per active edge when out_ready is held high.
- Full: all v=1 and out_ready=0 → in_ready=0; a stalled word is held indefinitely with data stable.
- Simultaneous accept and emit when full: out_ready=1 → the whole chain shifts and stage 0 accepts in the same edge; count unchanged.
- count = popcount(v); equals DEPTH when full; updated on the same edge as v.
- Ordering: words leave in acceptance order. No drop, no duplication.
- Reset mid-operation: all in-flight words are discarded; after release, the first accepted word is the first emitted.
- in_valid while in_ready=0: no state change. Upstream must hold in_data stable until accepted.
- DEPTH=1: single stage; in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: DFFN_PIPE_SR_SCAN_EN.
- With the macro defined, ports SE (input 1), SI (input 1) and SO (output 1) are added.
  - When SE=1, every active edge shifts all DEPTH*(WIDTH+1) flops (data then valid, stage 0 to DEPTH-1) as one chain: SI enters at d[0][0], SO = v[DEPTH-1].
  - The handshake is ignored; in_ready=0.
  - RSTB/SETB keep their async priority over scan.
- Without the macro: no scan ports and no scan muxing; behaviour as above.

Test Plan:
- Reset: RSTB=0 mid-stream with 2 valid words, SETB=1 → same cycle out_valid=0, count=0, out_data=8'h00; after release with in_valid=1 and data 8'h11, out_data=8'h11 after 2 falling edges.
- Set/dominance: SETB=0, RSTB=1 → out_data=8'hFF, count=0. Then drop RSTB while SETB=0 → out_data=8'h00. Release RSTB only → out_data=8'hFF.
- Streaming: DEPTH=2, out_ready=1, inputs 8'h01..8'h05 on consecutive falling edges → outputs 8'h01..8'h05 on consecutive edges starting 2 edges later. Rising edges cause no change.
- Back-pressure: out_ready=0, feed 8'hA1, 8'hA2, 8'hA3 → count=2 and in_ready=0; 8'hA3 held upstream. Raise out_ready → outputs A1, A2, A3 in order, with count staying 2 during the simultaneous accept/emit edge.
- Bubble collapse: DEPTH=4 with words in stages 1 and 3 only and out_ready=0 → next edge places them in stages 2 and 3; in_ready stays 1.
- NEG_EDGE=0, DEPTH=1: word 8'h5A accepted on a rising edge and out_valid=1 after one rising edge. With the scan macro, shifting pattern 1,0,1 with SE=1 appears on SO after (WIDTH+1)*DEPTH edges.
